lsu: RTL



---
 rtl/lsu.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: takes one execute-stage packet at a time, performs at most one
// AXI4-Lite read or write, and returns a registered writeback packet.
module lsu #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_pre_valid,
   output logic              o_pre_ready,
   output logic              o_post_valid,
   input  logic              i_post_ready,
   input  logic [DATA_W-1:0] i_lsu_exu_res,
   input  logic              i_lsu_is_load,
   input  logic              i_lsu_is_store,
   input  logic [2:0]        i_lsu_func3,
   input  logic [DATA_W-1:0] i_lsu_rs2,
   input  logic [4:0]        i_lsu_rd_id,
   input  logic              i_lsu_gpr_wen,
   output logic [DATA_W-1:0] o_lsu_wb_data,
   output logic [4:0]        o_lsu_rd_id,
   output logic              o_lsu_gpr_wen,
   output logic              o_lsu_acc_err,
   output logic [ADDR_W-1:0] o_araddr,
   output logic              o_arvalid,
   input  logic              i_arready,
   input  logic [DATA_W-1:0] i_rdata,
   input  logic [1:0]        i_rresp,
   input  logic              i_rvalid,
   output logic              o_rready,
   output logic [ADDR_W-1:0] o_awaddr,
   output logic              o_awvalid,
   input  logic              i_awready,
   output logic [DATA_W-1:0] o_wdata,
   output logic [3:0]        o_wstrb,
   output logic              o_wvalid,
   input  logic              i_wready,
   input  logic [1:0]        i_bresp,
   input  logic              i_bvalid,
   output logic              o_bready
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_RD_ADDR = 3'd1;
   localparam logic [2:0] S_RD_DATA = 3'd2;
   localparam logic [2:0] S_WR_REQ  = 3'd3;
   localparam logic [2:0] S_WR_RESP = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]        state_q,   state_d;
   logic [ADDR_W-1:0] addr_q,    addr_d;
   logic [2:0]        func3_q,   func3_d;
   logic [4:0]        rd_id_q,   rd_id_d;
   logic              gpr_wen_q, gpr_wen_d;
   logic [DATA_W-1:0] wb_data_q, wb_data_d;
   logic [DATA_W-1:0] wdata_q,   wdata_d;
   logic [3:0]        wstrb_q,   wstrb_d;
   logic              acc_err_q, acc_err_d;
   logic              aw_done_q, aw_done_d;
   logic              w_done_q,  w_done_d;

   logic              func3_bad, misaligned, req_err;
   logic [DATA_W-1:0] st_wdata;
   logic [3:0]        st_wstrb;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;
   logic [DATA_W-1:0] ld_data;

   // Request decode, evaluated on the incoming packet so errors are known at accept.
   always_comb begin
      func3_bad = 1'b0;
      if (i_lsu_is_load)
         func3_bad = !(i_lsu_func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
      else if (i_lsu_is_store)
         func3_bad = !(i_lsu_func3 inside {3'b000, 3'b001, 3'b010});
      misaligned = (i_lsu_is_load | i_lsu_is_store) &
                   (((i_lsu_func3[1:0] == 2'b01) & i_lsu_exu_res[0]) |
                    ((i_lsu_func3[1:0] == 2'b10) & (i_lsu_exu_res[1:0] != 2'b00)));
      req_err = func3_bad | misaligned | (i_lsu_is_load & i_lsu_is_store);

      case (i_lsu_func3[1:0])
         2'b00: begin
            st_wdata = {4{i_lsu_rs2[7:0]}};
            st_wstrb = 4'b0001 << i_lsu_exu_res[1:0];
         end
         2'b01: begin
            st_wdata = {2{i_lsu_rs2[15:0]}};
            st_wstrb = 4'b0011 << {i_lsu_exu_res[1], 1'b0};
         end
         default: begin
            st_wdata = i_lsu_rs2;
            st_wstrb = 4'b1111;
         end
      endcase
   end

   // Load lane select and extension from the latched address and width code.
   always_comb begin
      ld_byte = i_rdata[{addr_q[1:0], 3'b000} +: 8];
      ld_half = i_rdata[{addr_q[1], 4'b0000} +: 16];
      case (func3_q)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_data = {24'd0, ld_byte};
         3'b101:  ld_data = {16'd0, ld_half};
         default: ld_data = i_rdata;
      endcase
   end

   always_comb begin
      // NOTE: every next-state signal defaults to its register so no path leaves it unassigned (no latches).
      state_d   = state_q;
      addr_d    = addr_q;
      func3_d   = func3_q;
      rd_id_d   = rd_id_q;
      gpr_wen_d = gpr_wen_q;
      wb_data_d = wb_data_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      acc_err_d = acc_err_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;

      case (state_q)
         S_IDLE: begin
            if (i_pre_valid) begin
               addr_d    = i_lsu_exu_res[ADDR_W-1:0];
               func3_d   = i_lsu_func3;
               rd_id_d   = i_lsu_rd_id;
               gpr_wen_d = i_lsu_gpr_wen;
               wb_data_d = i_lsu_exu_res;
               acc_err_d = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               if (req_err) begin
                  acc_err_d = 1'b1;
                  gpr_wen_d = 1'b0;
                  state_d   = S_DONE;
               end else if (i_lsu_is_load) begin
                  state_d = S_RD_ADDR;
               end else if (i_lsu_is_store) begin
                  gpr_wen_d = 1'b0;
                  wb_data_d = '0;
                  wdata_d   = st_wdata;
                  wstrb_d   = st_wstrb;
                  state_d   = S_WR_REQ;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_RD_ADDR: if (i_arready) state_d = S_RD_DATA;
         S_RD_DATA: begin
            if (i_rvalid) begin
               wb_data_d = ld_data;
               if (i_rresp != 2'b00) begin
                  acc_err_d = 1'b1;
                  gpr_wen_d = 1'b0;
               end
               state_d = S_DONE;
            end
         end
         S_WR_REQ: begin
            // Address and data channels complete independently, in either order.
            aw_done_d = aw_done_q | i_awready;
            w_done_d  = w_done_q | i_wready;
            if (aw_done_d && w_done_d) state_d = S_WR_RESP;
         end
         S_WR_RESP: begin
            if (i_bvalid) begin
               if (i_bresp != 2'b00) acc_err_d = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE:  if (i_post_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         func3_q   <= '0;
         rd_id_q   <= '0;
         gpr_wen_q <= 1'b0;
         wb_data_q <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         acc_err_q <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         func3_q   <= func3_d;
         rd_id_q   <= rd_id_d;
         gpr_wen_q <= gpr_wen_d;
         wb_data_q <= wb_data_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         acc_err_q <= acc_err_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
      end
   end

   assign o_pre_ready   = (state_q == S_IDLE);
   assign o_post_valid  = (state_q == S_DONE);
   assign o_lsu_wb_data = wb_data_q;
   assign o_lsu_rd_id   = rd_id_q;
   assign o_lsu_gpr_wen = gpr_wen_q;
   assign o_lsu_acc_err = acc_err_q;
   assign o_araddr      = addr_q;
   assign o_arvalid     = (state_q == S_RD_ADDR);
   assign o_rready      = (state_q == S_RD_DATA);
   assign o_awaddr      = addr_q;
   assign o_awvalid     = (state_q == S_WR_REQ) && !aw_done_q;
   assign o_wdata       = wdata_q;
   assign o_wstrb       = wstrb_q;
   assign o_wvalid      = (state_q == S_WR_REQ) && !w_done_q;
   assign o_bready      = (state_q == S_WR_RESP);

endmodule
